ram_master: RTL and testbench

//  Initiator side of the 4x8 RAM port (select s0/s1, data, rw, clk, out).

---
 rtl/ram_master.sv | 210 +++++++++++++++++++++
 tb/tb_ram_master.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_master.sv
// ram_master: initiator for the 4x8 RAM port.
// Takes single read/write or whole-array fill commands over a valid/ready
// handshake, sequences the RAM pins and returns one response pulse per command.
// Optional build macro RAM_READBACK_EN: each write cycle is followed by a
// read-back verify cycle. rsp_err reports any mismatch, and rsp_rdata returns
// the value read back.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | req_ready=1, waiting for req_valid
// WR     | single write cycle, mem_rw=1
// RD     | single read cycle, mem_out sampled at cycle end
// FILL   | one write cycle per address, addr_q acts as the sweep counter
// VFY    | read-back of the address just written (RAM_READBACK_EN only)
// RESP   | rsp_valid=1 for exactly one cycle
module ram_master #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic          req_fill,
  input  logic [1:0]    req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          mem_s0,
  output logic          mem_s1,
  output logic [DW-1:0] mem_data,
  output logic          mem_rw,
  input  logic [DW-1:0] mem_out
);

  localparam logic [1:0] LAST_ADDR = 2'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_FILL = 3'd3,
`ifdef RAM_READBACK_EN
    S_VFY  = 3'd4,
`endif
    S_RESP = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
`ifdef RAM_READBACK_EN
  logic          fill_q, fill_d;
  logic          err_acc_q, err_acc_d;
`endif

  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [1:0]    mem_sel_q, mem_sel_d;
  logic [DW-1:0] mem_data_q, mem_data_d;
  logic          mem_rw_q, mem_rw_d;

  // State and command/response datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= 2'b00;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
`ifdef RAM_READBACK_EN
      fill_q    <= 1'b0;
      err_acc_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
`ifdef RAM_READBACK_EN
      fill_q    <= fill_d;
      err_acc_q <= err_acc_d;
`endif
    end
  end

  // Next-state decode; the response fields only change on entry to RESP
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
`ifdef RAM_READBACK_EN
    fill_d    = fill_q;
    err_acc_d = err_acc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          wdata_d = req_wdata;
`ifdef RAM_READBACK_EN
          fill_d    = req_fill;
          err_acc_d = 1'b0;
`endif
          if (req_fill) begin
            addr_d  = 2'b00;
            state_d = S_FILL;
          end else begin
            addr_d  = req_addr;
            state_d = req_write ? S_WR : S_RD;
          end
        end
      end
      S_WR: begin
`ifdef RAM_READBACK_EN
        state_d = S_VFY;
`else
        state_d = S_RESP;
        rdata_d = wdata_q;
        err_d   = 1'b0;
`endif
      end
      S_RD: begin
        state_d = S_RESP;
        rdata_d = mem_out;
        err_d   = 1'b0;
      end
      S_FILL: begin
`ifdef RAM_READBACK_EN
        state_d = S_VFY;
`else
        addr_d = addr_q + 2'd1;
        if (addr_q == LAST_ADDR) begin
          state_d = S_RESP;
          rdata_d = wdata_q;
          err_d   = 1'b0;
        end
`endif
      end
`ifdef RAM_READBACK_EN
      S_VFY: begin
        err_acc_d = err_acc_q | (mem_out != wdata_q);
        if (!fill_q || (addr_q == LAST_ADDR)) begin
          state_d = S_RESP;
          rdata_d = mem_out;
          err_d   = err_acc_d;
        end else begin
          state_d = S_FILL;
          addr_d  = addr_q + 2'd1;
        end
      end
`endif
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every pin comes straight off a flop
  always_comb begin
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    mem_rw_d    = (state_d == S_WR) || (state_d == S_FILL);
    mem_sel_d   = 2'b00;
    mem_data_d  = '0;
    case (state_d)
      S_WR, S_FILL: begin
        mem_sel_d  = addr_d;
        mem_data_d = wdata_d;
      end
      S_RD: mem_sel_d = addr_d;
`ifdef RAM_READBACK_EN
      S_VFY: mem_sel_d = addr_d;
`endif
      default: ;
    endcase
  end

  // Registered RAM pins and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      mem_sel_q   <= 2'b00;
      mem_data_q  <= '0;
      mem_rw_q    <= 1'b0;
    end else begin
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      mem_sel_q   <= mem_sel_d;
      mem_data_q  <= mem_data_d;
      mem_rw_q    <= mem_rw_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_s0    = mem_sel_q[1];
  assign mem_s1    = mem_sel_q[0];
  assign mem_data  = mem_data_q;
  assign mem_rw    = mem_rw_q;

endmodule

// File: tb/tb_ram_master.sv
// Bench for ram_master: a behavioural 4x8 RAM is attached to the pins, and an
// expected-contents array predicts every response. It also checks latency,
// the write-beat addresses, the reset behaviour and back-to-back handshakes.
module tb_ram_master;

`ifdef RAM_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_write, req_fill;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       mem_s0, mem_s1, mem_rw;
  logic [7:0] mem_data, mem_out;

  logic [7:0] ram [4] = '{default: 8'h00};
  logic [7:0] exp_mem [4] = '{default: 8'h00};
  logic       stuck = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  ram_master #(.DW(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_fill(req_fill), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_s0(mem_s0), .mem_s1(mem_s1), .mem_data(mem_data), .mem_rw(mem_rw),
    .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // RAM: write at rising edge when mem_rw=1, combinational read; optional bit0 stuck-at-0
  always @(posedge clk) begin
    if (mem_rw) ram[{mem_s0, mem_s1}] <= stuck ? (mem_data & 8'hFE) : mem_data;
  end
  assign mem_out = ram[{mem_s0, mem_s1}];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  function automatic logic [7:0] stored(input logic [7:0] v);
    return stuck ? (v & 8'hFE) : v;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rdata"}, rsp_rdata, 0);
    chk({tag, "_err"}, rsp_err, 0);
    chk({tag, "_sel"}, {mem_s0, mem_s1}, 0);
    chk({tag, "_mem_data"}, mem_data, 0);
    chk({tag, "_mem_rw"}, mem_rw, 0);
  endtask

  // Issue one command from a negedge, follow it to its response, compare with the model
  task automatic do_cmd(input bit fill, input bit wr, input logic [1:0] addr, input logic [7:0] wd);
    int         lat;
    int         exp_lat;
    logic [1:0] beats[$];
    logic [1:0] exp_beats[$];
    logic [7:0] exp_rd;
    logic       exp_err;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    chk("ready_before_cmd", req_ready, 1);
    req_valid = 1'b1; req_fill = fill; req_write = wr; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_fill = 1'($urandom); req_write = 1'($urandom);
    req_addr = 2'($urandom); req_wdata = 8'($urandom);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1 && !fill && !wr) begin
        chk("rd_sel", {mem_s0, mem_s1}, addr);
        chk("rd_rw", mem_rw, 0);
      end
      if (mem_rw) begin
        beats.push_back({mem_s0, mem_s1});
        chk("beat_data", mem_data, wd);
      end
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    if (fill) begin
      for (int a = 0; a < 4; a++) begin
        exp_mem[a] = stored(wd);
        exp_beats.push_back(2'(a));
      end
      exp_rd  = RB ? stored(wd) : wd;
      exp_err = RB && (stored(wd) != wd);
      exp_lat = RB ? 9 : 5;
    end else if (wr) begin
      exp_mem[addr] = stored(wd);
      exp_beats.push_back(addr);
      exp_rd  = RB ? stored(wd) : wd;
      exp_err = RB && (stored(wd) != wd);
      exp_lat = RB ? 3 : 2;
    end else begin
      exp_rd  = exp_mem[addr];
      exp_err = 1'b0;
      exp_lat = 2;
    end
    chk("latency", lat, exp_lat);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err", rsp_err, exp_err);
    chk("n_write_beats", beats.size(), exp_beats.size());
    for (int i = 0; i < beats.size() && i < exp_beats.size(); i++)
      chk("beat_addr", beats[i], exp_beats[i]);
    @(negedge clk);
    chk("rsp_one_cycle", rsp_valid, 0);
    chk("ready_after_rsp", req_ready, 1);
  endtask

  logic [7:0] d5 [3];
  logic [1:0] a5 [3];
  int         acc_cyc[$];
  int         n_acc, npulse;
  bit         prev_v, accept, found;
  int         kind;

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_fill = 1'b0; req_addr = 2'b00; req_wdata = 8'h00;
    #12;
    chk_reset("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // write 0xA5 at 2, read it back
    do_cmd(1'b0, 1'b1, 2'd2, 8'hA5);
    do_cmd(1'b0, 1'b0, 2'd2, 8'h00);
    chk("t2_read", rsp_rdata, 8'hA5);

    // fill 0x3C then read every word
    do_cmd(1'b1, 1'b0, 2'd0, 8'h3C);
    for (int a = 0; a < 4; a++) begin
      do_cmd(1'b0, 1'b0, 2'(a), 8'h00);
      chk("t3_read", rsp_rdata, 8'h3C);
    end

    // fill wins over req_write=0 / req_addr=1
    do_cmd(1'b1, 1'b0, 2'd1, 8'h5A);
    for (int a = 0; a < 4; a++) begin
      do_cmd(1'b0, 1'b0, 2'(a), 8'h00);
      chk("t4_read", rsp_rdata, 8'h5A);
    end

    // reset in the middle of a fill, while address 2 is being written
    req_valid = 1'b1; req_fill = 1'b1; req_write = 1'b0; req_addr = 2'd0; req_wdata = 8'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_rw && {mem_s0, mem_s1} == 2'd2) begin
        found = 1'b1;
        break;
      end
    end
    chk("t1_reached_addr2", found, 1);
    rst_n = 1'b0;
    #1;
    chk_reset("t1_async");
    @(negedge clk);
    chk_reset("t1_held");
    rst_n = 1'b1;
    exp_mem[0] = 8'h77;
    exp_mem[1] = 8'h77;
    npulse = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid) npulse++;
    end
    chk("t1_no_rsp", npulse, 0);
    chk("t1_ready", req_ready, 1);
    for (int a = 0; a < 4; a++) do_cmd(1'b0, 1'b0, 2'(a), 8'h00);

    // req_valid held high across three writes
    a5[0] = 2'd0; a5[1] = 2'd3; a5[2] = 2'd1;
    for (int i = 0; i < 3; i++) begin
      d5[i] = 8'($urandom);
      exp_mem[a5[i]] = stored(d5[i]);
    end
    n_acc = 0; npulse = 0; prev_v = 1'b0;
    req_valid = 1'b1; req_fill = 1'b0; req_write = 1'b1; req_addr = a5[0]; req_wdata = d5[0];
    for (int c = 0; c < 40; c++) begin
      accept = req_valid && req_ready;
      if (rsp_valid) begin
        chk("t5_pulse_width", prev_v, 0);
        if (npulse < 3) chk("t5_order", rsp_rdata, d5[npulse]);
        npulse++;
      end
      prev_v = rsp_valid;
      @(posedge clk); #1;
      if (accept) begin
        acc_cyc.push_back(c);
        n_acc++;
        if (n_acc == 3) req_valid = 1'b0;
        else begin
          req_addr = a5[n_acc];
          req_wdata = d5[n_acc];
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("t5_pulses", npulse, 3);
    chk("t5_accepts", acc_cyc.size(), 3);
    if (acc_cyc.size() == 3) begin
      chk("t5_spacing1", acc_cyc[1] - acc_cyc[0], RB ? 4 : 3);
      chk("t5_spacing2", acc_cyc[2] - acc_cyc[1], RB ? 4 : 3);
    end
    for (int i = 0; i < 3; i++) do_cmd(1'b0, 1'b0, a5[i], 8'h00);

    // randomized mix against the model
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 9);
      do_cmd(kind < 2, kind < 6, 2'($urandom), 8'($urandom));
    end

`ifdef RAM_READBACK_EN
    // bit0 stuck-at-0 in the RAM: readback must flag 0x01 but not 0x02
    stuck = 1'b1;
    do_cmd(1'b0, 1'b1, 2'd1, 8'h01);
    chk("t6_err_set", rsp_err, 1);
    chk("t6_rdata", rsp_rdata, 8'h00);
    do_cmd(1'b0, 1'b1, 2'd1, 8'h02);
    chk("t6_err_clear", rsp_err, 0);
    stuck = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
